// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-schedule path.
// Contents:
//   mode_e        start/mode encodings (3 is reserved and behaves as idle)
//   *_FIRST/*_LAST default key-BRAM word windows for the two schedules
//   round_key_t   one packed FIFO entry {data, round, last}
//   mode_active() true for the two modes that capture key words
package aes_key_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_ENC  = 2'd1,
        MODE_DEC  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int unsigned ENC_FIRST   = 0;
    localparam int unsigned ENC_LAST    = 59;
    localparam int unsigned DEC_FIRST   = 60;
    localparam int unsigned DEC_LAST    = 119;

    localparam int ROUND_KEY_W = 128;
    localparam int KEY_WORD_W  = 32;
    localparam int ROUND_W     = 4;

    typedef struct packed {
        logic [ROUND_KEY_W-1:0] data;
        logic [ROUND_W-1:0]     round;
        logic                   last;
    } round_key_t;

    function automatic logic mode_active(input mode_e m);
        return (m == MODE_ENC) || (m == MODE_DEC);
    endfunction

endpackage

// File: rtl/rk_fifo.sv
// Synchronous first-word-fall-through FIFO built as a shift register:
// entry 0 is always the head, so dout comes straight from a flop.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   flush       synchronous clear (same effect as rst)
//   push, din   write request and data; ignored when full unless popping
//   pop         read request; ignored when empty
//   dout        head entry
//   full, empty, count  registered occupancy status
module rk_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic             empty_r;

    logic             pop_s;
    logic             push_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [CNT_W-1:0] count_nxt_s;

    // Qualify requests; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        pop_s    = pop && !empty_r;
        push_s   = push && (!full_r || pop_s);
        wr_idx_s = pop_s ? IDX_W'(count_r - ONE_C) : IDX_W'(count_r);
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage shift/write and occupancy flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_r[i] <= mem_r[i+1];
                end
            end
            // Write after the shift so it lands in the post-pop slot.
            if (push_s) begin
                mem_r[wr_idx_s] <= din;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == '0);
        end
    end

    assign dout  = mem_r[0];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/round_key_packer.sv
// Packs the 32-bit key-BRAM read stream into 128-bit round keys and hands
// them to the round datapath through a small FWFT FIFO.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      requested mode (0 idle, 1 encrypt, 2 decrypt, 3 idle); a
//              change restarts the block
//   key_addr   address the key counter drives to the BRAM this cycle
//   key_word   BRAM data for the previous cycle's key_addr
//   rk_*       FIFO head: data (word 0 in MSBs), round index, last flag, valid
//   rk_ready   datapath accepts the head
//   done       whole schedule delivered and FIFO drained
//   overflow   sticky: a round key was dropped on a full FIFO
module round_key_packer
    import aes_key_pkg::*;
#(
    parameter int unsigned ENC_FIRST  = aes_key_pkg::ENC_FIRST,
    parameter int unsigned ENC_LAST   = aes_key_pkg::ENC_LAST,
    parameter int unsigned DEC_FIRST  = aes_key_pkg::DEC_FIRST,
    parameter int unsigned DEC_LAST   = aes_key_pkg::DEC_LAST,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             start,
    input  logic [7:0]             key_addr,
    input  logic [KEY_WORD_W-1:0]  key_word,
    output logic [ROUND_KEY_W-1:0] rk_data,
    output logic [ROUND_W-1:0]     rk_round,
    output logic                   rk_last,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic                   done,
    output logic                   overflow
);

    // LAST+1 must still fit the 8-bit expected-address register.
    if (ENC_LAST > 254 || DEC_LAST > 254) begin : g_bad_last
        $error("round_key_packer: LAST address must be <= 254");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("round_key_packer: FIFO_DEPTH must be a power of two >= 2");
    end

    localparam logic [7:0] ENC_FIRST_A = 8'(ENC_FIRST);
    localparam logic [7:0] ENC_LAST_A  = 8'(ENC_LAST);
    localparam logic [7:0] DEC_FIRST_A = 8'(DEC_FIRST);
    localparam logic [7:0] DEC_LAST_A  = 8'(DEC_LAST);
    localparam int         CNT_W       = $clog2(FIFO_DEPTH) + 1;

    mode_e                 mode_q_r;
    logic [7:0]            addr_d1_r;
    logic [7:0]            exp_addr_r;
    logic [7:0]            last_addr_r;
    logic [1:0]            word_idx_r;
    logic [KEY_WORD_W-1:0] w0_r;
    logic [KEY_WORD_W-1:0] w1_r;
    logic [KEY_WORD_W-1:0] w2_r;
    logic [ROUND_W-1:0]    round_r;
    logic                  done_r;
    logic                  overflow_r;

    logic                  restart_s;
    logic                  active_s;
    logic                  capture_s;
    logic                  push_s;
    logic                  pop_s;
    round_key_t            push_key_s;
    round_key_t            head_key_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    // Capture/push decode. addr_d1_r lines up with key_word (1-cycle BRAM).
    always_comb begin
        restart_s = (mode_e'(start) != mode_q_r);
        active_s  = mode_active(mode_q_r);
        // The bound check stops a held terminal address from re-matching.
        capture_s = active_s && !restart_s &&
                    (addr_d1_r == exp_addr_r) && (exp_addr_r <= last_addr_r);
        push_s    = capture_s && (word_idx_r == 2'd3);
        pop_s     = rk_ready && !fifo_empty_s;
        push_key_s.data  = {w0_r, w1_r, w2_r, key_word};
        push_key_s.round = round_r;
        push_key_s.last  = (addr_d1_r == last_addr_r);
    end

    // Mode tracking, packer state, round counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_r    <= MODE_IDLE;
            addr_d1_r   <= 8'd0;
            exp_addr_r  <= ENC_FIRST_A;
            last_addr_r <= ENC_LAST_A;
            word_idx_r  <= 2'd0;
            w0_r        <= '0;
            w1_r        <= '0;
            w2_r        <= '0;
            round_r     <= '0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            mode_q_r  <= mode_e'(start);
            addr_d1_r <= key_addr;
            if (restart_s) begin
                exp_addr_r  <= (mode_e'(start) == MODE_DEC) ? DEC_FIRST_A : ENC_FIRST_A;
                last_addr_r <= (mode_e'(start) == MODE_DEC) ? DEC_LAST_A : ENC_LAST_A;
                word_idx_r  <= 2'd0;
                w0_r        <= '0;
                w1_r        <= '0;
                w2_r        <= '0;
                round_r     <= '0;
                done_r      <= 1'b0;
                overflow_r  <= 1'b0;
            end else begin
                if (capture_s) begin
                    // Slot 3 is never stored: it goes straight into the push.
                    case (word_idx_r)
                        2'd0:    w0_r <= key_word;
                        2'd1:    w1_r <= key_word;
                        2'd2:    w2_r <= key_word;
                        default: ;
                    endcase
                    word_idx_r <= word_idx_r + 2'd1;
                    exp_addr_r <= exp_addr_r + 8'd1;
                end
                if (push_s) begin
                    round_r <= round_r + 4'd1;
                end
                if (push_s && fifo_full_s && !pop_s) begin
                    overflow_r <= 1'b1;
                end
                if (active_s && (exp_addr_r > last_addr_r) && (fifo_count_s == '0)) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    rk_fifo #(
        .WIDTH ($bits(round_key_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (restart_s),
        .push  (push_s),
        .din   (push_key_s),
        .pop   (pop_s),
        .dout  (head_key_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign rk_data  = head_key_s.data;
    assign rk_round = head_key_s.round;
    assign rk_last  = head_key_s.last;
    assign rk_valid = !fifo_empty_s;
    assign done     = done_r;
    assign overflow = overflow_r;

endmodule
